prio_event_encoder_8to3: RTL and testbench

- Sequential 8-to-3 priority encoder: the encode-side counterpart of the 3-to-8 one-hot decoders.
- Captures rising edges on 8 request lines into a sticky pending register.
- Presents the highest-priority enabled pending index as a 3-bit code with a valid/ack handshake, and retires each event on acknowledge.
- Sits between raw event/interrupt sources and a consumer that uses the code to index or re-decode the source.

---
 rtl/prio_event_encoder_8to3.sv | 151 +++++++++++++++
 tb/tb_prio_event_encoder_8to3.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prio_event_encoder_8to3.sv
// prio_event_encoder_8to3
//   Sequential 8-to-3 priority encoder. Rising edges on req are captured
//   into a sticky pending register. The highest-priority pending line that
//   is also enabled by mask is presented as a 3-bit code under a valid/ack
//   handshake. An accepted handshake retires that event.
//
// Ports
//   clk          system clock, rising-edge active
//   rst_n        asynchronous active-low reset
//   req[7:0]     event request lines (synchronous to clk)
//   mask[7:0]    per-line enable, 1 = eligible for presentation
//   ack          consumer accepts the presented code
//   clr_ovr      clears all overrun flags
//   code[2:0]    encoded index of the presented event
//   valid        code is valid and held stable
//   pending[7:0] sticky pending events
//   any_pending  OR of pending, ignoring mask
//   overrun[7:0] sticky: a rising edge arrived while that bit was pending
//   ack_err      one-cycle pulse after an ack seen while valid=0
//   serviced_cnt count of accepted handshakes, wraps
module prio_event_encoder_8to3 #(
    parameter int CNT_W      = 8,
    parameter bit HIGH_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       req,
    input  logic [7:0]       mask,
    input  logic             ack,
    input  logic             clr_ovr,
    output logic [2:0]       code,
    output logic             valid,
    output logic [7:0]       pending,
    output logic             any_pending,
    output logic [7:0]       overrun,
    output logic             ack_err,
    output logic [CNT_W-1:0] serviced_cnt
);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [2:0]       code_reg, code_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [7:0]       req_d_reg;
    logic [7:0]       pending_reg, pending_next;
    logic [7:0]       overrun_reg, overrun_next;
    logic             ack_err_reg;

    logic [7:0]       rise;
    logic [7:0]       clr;
    logic [7:0]       eligible;
    logic             accept;

    // Index of the winning bit; the later iteration overrides, so the loop
    // direction selects which end of the vector has priority.
    function automatic logic [2:0] prio_index(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        if (HIGH_FIRST) begin
            for (int i = 0; i < 8; i++) begin
                if (v[i]) idx = 3'(i);
            end
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (v[i]) idx = 3'(i);
            end
        end
        return idx;
    endfunction

    assign rise     = req & ~req_d_reg;
    assign accept   = ack && (state_reg == PRESENT);
    assign eligible = pending_reg & mask;

    // Per-bit retire and sticky-flag update. A fresh rise always wins over
    // a retire on the same bit, so an event arriving during its own ack is
    // kept pending and does not count as an overrun.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_bit
            assign clr[gi]          = accept && (code_reg == 3'(gi));
            assign pending_next[gi] = (pending_reg[gi] & ~clr[gi]) | rise[gi];
            assign overrun_next[gi] = (overrun_reg[gi] & ~clr_ovr)
                                    | (rise[gi] & pending_reg[gi] & ~clr[gi]);
        end
    endgenerate

    // FSM state register and handshake-owned registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            code_reg  <= 3'd0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            code_reg  <= code_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state logic. The code is latched only on the IDLE->PRESENT
    // transition, so mask/req/pending changes cannot disturb a presented code.
    always_comb begin
        state_next = state_reg;
        code_next  = code_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (|eligible) begin
                    code_next  = prio_index(eligible);
                    state_next = PRESENT;
                end
            end
            PRESENT: begin
                if (ack) begin
                    cnt_next   = cnt_reg + CNT_W'(1);
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Edge detector, event bookkeeping and ack error pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_d_reg   <= 8'h00;
            pending_reg <= 8'h00;
            overrun_reg <= 8'h00;
            ack_err_reg <= 1'b0;
        end else begin
            req_d_reg   <= req;
            pending_reg <= pending_next;
            overrun_reg <= overrun_next;
            ack_err_reg <= ack && (state_reg == IDLE);
        end
    end

    assign code         = code_reg;
    assign valid        = (state_reg == PRESENT);
    assign pending      = pending_reg;
    assign any_pending  = |pending_reg;
    assign overrun      = overrun_reg;
    assign ack_err      = ack_err_reg;
    assign serviced_cnt = cnt_reg;

endmodule

// File: tb/tb_prio_event_encoder_8to3.sv
module tb_prio_event_encoder_8to3;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] mask;
    logic       ack;
    logic       clr_ovr;

    // high-first instance
    logic [2:0] code;
    logic       valid;
    logic [7:0] pending;
    logic       any_pending;
    logic [7:0] overrun;
    logic       ack_err;
    logic [7:0] serviced_cnt;

    // low-first instance, driven by the same inputs
    logic [2:0] code_lf;
    logic       valid_lf;
    logic [7:0] pending_lf;
    logic       any_pending_lf;
    logic [7:0] overrun_lf;
    logic       ack_err_lf;
    logic [7:0] serviced_cnt_lf;

    int n_checks = 0;
    int n_errors = 0;
    int cnt_exp  = 0;

    logic [2:0] exp_q[$];
    logic [2:0] exp_lf_q[$];

    prio_event_encoder_8to3 #(.CNT_W(8), .HIGH_FIRST(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .mask(mask), .ack(ack),
        .clr_ovr(clr_ovr), .code(code), .valid(valid), .pending(pending),
        .any_pending(any_pending), .overrun(overrun), .ack_err(ack_err),
        .serviced_cnt(serviced_cnt)
    );

    prio_event_encoder_8to3 #(.CNT_W(8), .HIGH_FIRST(1'b0)) dut_lf (
        .clk(clk), .rst_n(rst_n), .req(req), .mask(mask), .ack(ack),
        .clr_ovr(clr_ovr), .code(code_lf), .valid(valid_lf), .pending(pending_lf),
        .any_pending(any_pending_lf), .overrun(overrun_lf), .ack_err(ack_err_lf),
        .serviced_cnt(serviced_cnt_lf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance to 1 time unit after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // wait (bounded) for valid, then pop the scoreboard and compare the code
    task automatic expect_present(input string tag, input bit with_lf);
        logic [2:0] e;
        int k;
        k = 0;
        while (valid !== 1'b1 && k < 8) begin
            step();
            k++;
        end
        check({tag, "_valid"}, 32'(valid), 32'd1);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_code"}, 32'(code), 32'(e));
        end
        if (with_lf) begin
            check({tag, "_lf_valid"}, 32'(valid_lf), 32'd1);
            if (exp_lf_q.size() == 0) begin
                check({tag, "_lf_sb_empty"}, 32'(exp_lf_q.size()), 32'd1);
            end else begin
                e = exp_lf_q.pop_front();
                check({tag, "_lf_code"}, 32'(code_lf), 32'(e));
            end
        end
    endtask

    task automatic do_ack(input bit verbose);
        if (verbose) $display("handshake: code=%0d cnt=%0d", code, serviced_cnt);
        ack = 1'b1;
        step();
        ack = 1'b0;
        cnt_exp = (cnt_exp + 1) % 256;
    endtask

    initial begin
        rst_n   = 1'b0;
        req     = 8'h00;
        mask    = 8'hFF;
        ack     = 1'b0;
        clr_ovr = 1'b0;
        #3;
        check("rst_valid",   32'(valid), 32'd0);
        check("rst_code",    32'(code), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_any",     32'(any_pending), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_ackerr",  32'(ack_err), 32'd0);
        check("rst_cnt",     32'(serviced_cnt), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // single event on bit 0: pending after 1 clk, valid after 2
        req = 8'h01;
        exp_q.push_back(3'd0);
        step();
        req = 8'h00;
        check("t1_pending", 32'(pending), 32'h01);
        check("t1_valid_early", 32'(valid), 32'd0);
        step();
        check("t1_latency_valid", 32'(valid), 32'd1);
        expect_present("t1", 1'b0);
        do_ack(1'b1);
        check("t1_valid_after_ack", 32'(valid), 32'd0);
        check("t1_pending_after_ack", 32'(pending), 32'h00);
        check("t1_cnt", 32'(serviced_cnt), 32'(cnt_exp));

        // simultaneous bits 5 and 2; order depends on priority direction
        req = 8'h24;
        exp_q.push_back(3'd5);    exp_q.push_back(3'd2);
        exp_lf_q.push_back(3'd2); exp_lf_q.push_back(3'd5);
        step();
        req = 8'h00;
        step();
        expect_present("t2a", 1'b1);
        do_ack(1'b1);
        check("t2_idle_gap", 32'(valid), 32'd0);
        step();
        expect_present("t2b", 1'b1);
        do_ack(1'b1);
        check("t2_pending", 32'(pending), 32'h00);
        check("t2_lf_pending", 32'(pending_lf), 32'h00);
        check("t2_cnt", 32'(serviced_cnt), 32'(cnt_exp));

        // masked bit stays pending; code held while PRESENT despite mask
        mask = 8'h7F;
        req  = 8'h80;
        step();
        req = 8'h00;
        step();
        step();
        check("t3_masked_valid", 32'(valid), 32'd0);
        check("t3_masked_any", 32'(any_pending), 32'd1);
        check("t3_masked_pending", 32'(pending), 32'h80);
        mask = 8'hFF;
        exp_q.push_back(3'd7);
        step();
        expect_present("t3_unmask", 1'b0);
        mask = 8'h00;
        step();
        step();
        check("t3_hold_valid", 32'(valid), 32'd1);
        check("t3_hold_code", 32'(code), 32'd7);
        do_ack(1'b1);
        mask = 8'hFF;
        check("t3_pending", 32'(pending), 32'h00);

        // overrun on bit 3, then ack colliding with a new rise on bit 3
        req = 8'h08;
        exp_q.push_back(3'd3);
        step();
        req = 8'h00;
        step();
        expect_present("t4a", 1'b0);
        req = 8'h08;
        step();
        req = 8'h00;
        check("t4_overrun", 32'(overrun), 32'h08);
        step();
        req = 8'h08;
        exp_q.push_back(3'd3);
        do_ack(1'b1);
        req = 8'h00;
        check("t4_set_wins", 32'(pending), 32'h08);
        check("t4_no_new_ovr", 32'(overrun), 32'h08);
        check("t4_gap", 32'(valid), 32'd0);
        step();
        expect_present("t4b", 1'b0);
        clr_ovr = 1'b1;
        step();
        clr_ovr = 1'b0;
        check("t4_clr_ovr", 32'(overrun), 32'h00);
        do_ack(1'b1);

        // ack with nothing presented
        check("t5_idle", 32'(valid), 32'd0);
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("t5_ack_err", 32'(ack_err), 32'd1);
        check("t5_cnt_same", 32'(serviced_cnt), 32'(cnt_exp));
        step();
        check("t5_ack_err_pulse", 32'(ack_err), 32'd0);

        // handshake until the counter wraps
        while (cnt_exp != 0) begin
            req = 8'h01;
            step();
            req = 8'h00;
            step();
            if (cnt_exp == 255) check("t5_cnt_max", 32'(serviced_cnt), 32'd255);
            do_ack(1'b0);
        end
        check("t5_cnt_wrap", 32'(serviced_cnt), 32'd0);

        // asynchronous reset while presenting
        req = 8'h02;
        exp_q.push_back(3'd1);
        step();
        req = 8'h00;
        step();
        expect_present("t6a", 1'b0);
        req = 8'h02;
        step();
        req = 8'h00;
        check("t6_ovr_before", 32'(overrun), 32'h02);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_valid", 32'(valid), 32'd0);
        check("t6_async_code", 32'(code), 32'd0);
        check("t6_async_pending", 32'(pending), 32'h00);
        check("t6_async_overrun", 32'(overrun), 32'h00);
        check("t6_async_cnt", 32'(serviced_cnt), 32'd0);
        cnt_exp = 0;
        req = 8'h40;
        step();
        rst_n = 1'b1;
        exp_q.push_back(3'd6);
        step();
        check("t6_rel_pending", 32'(pending), 32'h40);
        check("t6_rel_valid_early", 32'(valid), 32'd0);
        step();
        check("t6_rel_latency", 32'(valid), 32'd1);
        expect_present("t6b", 1'b0);
        do_ack(1'b1);
        req = 8'h00;
        check("t6_pending", 32'(pending), 32'h00);
        check("t6_cnt", 32'(serviced_cnt), 32'(cnt_exp));
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
